// File: rtl/maze_mem_arbiter_pkg.sv
// maze_mem_arbiter_pkg: shared maze cell values, arbiter state encoding and default sizes
package maze_mem_arbiter_pkg;
    localparam int MAZE_WIDTH = 6;
    localparam int LOCK_MAX = 16;
    localparam logic [1:0] CORRIDOR = 2'd0;
    localparam logic [1:0] WALL = 2'd1;
    localparam logic [1:0] VISITED = 2'd2;
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_e;
endpackage

// File: rtl/maze_mem_arbiter_lock_timer.sv
// lock_timer: counts granted lock cycles; tc flags the increment that reaches lock_max-1
module lock_timer #(
    parameter int lock_max = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = lock_max > 2 ? $clog2(lock_max) : 1;
    logic [W-1:0] cnt;
    // Entry grant plus lock_max-1 locked grants gives lock_max consecutive grants.
    assign tc = enable && (cnt == W'(lock_max - 2));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: two-port round-robin arbiter with lock for a single-ported maze cell memory
module maze_mem_arbiter
    import maze_mem_arbiter_pkg::*;
#(
    parameter int maze_width = MAZE_WIDTH,
    parameter int lock_max = LOCK_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [maze_width-1:0] row0,
    input  logic [maze_width-1:0] col0,
    input  logic [maze_width-1:0] row1,
    input  logic [maze_width-1:0] col1,
    input  logic [1:0]            wdata0,
    input  logic [1:0]            wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [1:0]            rdata0,
    output logic [1:0]            rdata1,
    output logic [maze_width-1:0] mem_row,
    output logic [maze_width-1:0] mem_col,
    output logic                  mem_oe,
    output logic                  mem_we,
    output logic [1:0]            mem_wdata,
    input  logic [1:0]            mem_rdata
);
    arb_state_e state;
    logic ptr;
    logic any_gnt, sel_we, lock_enter, exit_lock, tc;
    logic [1:0] tag1, tag2;
    logic [1:0] rdata0_q, rdata1_q;
    always_comb begin
        gnt0 = rst_n && req0 && (state == LOCK0 || (state == ARB && (!req1 || !ptr)));
        gnt1 = rst_n && req1 && (state == LOCK1 || (state == ARB && (!req0 || ptr)));
        any_gnt = gnt0 || gnt1;
        sel_we = gnt1 ? we1 : we0;
        lock_enter = state == ARB && ((gnt0 && lock0) || (gnt1 && lock1));
        exit_lock = state == LOCK0 ? (!req0 || !lock0 || tc) : (!req1 || !lock1 || tc);
        rvalid0 = tag2[1] && !tag2[0];
        rvalid1 = tag2[1] && tag2[0];
        rdata0 = rvalid0 ? mem_rdata : rdata0_q;
        rdata1 = rvalid1 ? mem_rdata : rdata1_q;
    end
    lock_timer #(.lock_max(lock_max)) u_lock_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (lock_enter),
        .enable(state != ARB && any_gnt),
        .tc    (tc)
    );
    // tag {valid, port}: stage 1 tracks the strobe cycle, stage 2 the data-return cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            ptr       <= 1'b0;
            mem_row   <= '0;
            mem_col   <= '0;
            mem_wdata <= '0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            tag1      <= '0;
            tag2      <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            mem_oe <= any_gnt && !sel_we;
            mem_we <= any_gnt && sel_we;
            if (any_gnt) begin
                mem_row   <= gnt1 ? row1 : row0;
                mem_col   <= gnt1 ? col1 : col0;
                mem_wdata <= gnt1 ? wdata1 : wdata0;
                ptr       <= gnt0;
            end
            tag1 <= {any_gnt && !sel_we, gnt1};
            tag2 <= tag1;
            if (rvalid0)
                rdata0_q <= mem_rdata;
            if (rvalid1)
                rdata1_q <= mem_rdata;
            state <= state == ARB ? (gnt0 && lock0 ? LOCK0 : gnt1 && lock1 ? LOCK1 : ARB)
                                  : (exit_lock ? ARB : state);
        end
    end
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
endmodule
